// File: rtl/fpga_status_leds.sv
// Board status LED driver: per-channel off/on/heartbeat/PWM modes, with a
// program-exit override that shows pass (all lit) or fail (all blinking).
module fpga_status_leds #(
    parameter int unsigned NUM_LEDS  = 4,
    parameter int unsigned DIV_WIDTH = 27,
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [2*NUM_LEDS-1:0]         mode_i,
    input  logic [PWM_WIDTH*NUM_LEDS-1:0] duty_i,
    input  logic                          exit_valid_i,
    input  logic                          exit_value_i,
    output logic [NUM_LEDS-1:0]           led_o,
    output logic                          heartbeat_o,
    output logic                          exit_latched_o
);

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ON  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_HB  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_PWM = 2'b11;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_EXIT_PASS = 2'd1,
        ST_EXIT_FAIL = 2'd2
    } state_e;

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 exit_valid_q, exit_valid_d;
    state_e               state_q, state_d;
    logic                 exit_latched_q, exit_latched_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 exit_rise_c;
    logic                 heartbeat_c;

    assign heartbeat_c = div_cnt_q[DIV_WIDTH-1];
    assign exit_rise_c = exit_valid_i & ~exit_valid_q;

    // Free-running divider and PWM counters, unaffected by mode or state.
    always_comb begin
        div_cnt_d    = div_cnt_q + DIV_WIDTH'(1);
        pwm_cnt_d    = pwm_cnt_q + PWM_WIDTH'(1);
        exit_valid_d = exit_valid_i;
    end

    // Exit FSM: first exit edge picks pass/fail; exit states hold until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (exit_rise_c) begin
                    state_d = exit_value_i ? ST_EXIT_FAIL : ST_EXIT_PASS;
                end
            end
            ST_EXIT_PASS: state_d = ST_EXIT_PASS;
            ST_EXIT_FAIL: state_d = ST_EXIT_FAIL;
            default:      state_d = ST_NORMAL;
        endcase
        exit_latched_d = (state_d != ST_NORMAL);
    end

    // Per-channel LED selection; exit states override from the current state.
    always_comb begin
        led_d = '0;
        for (int unsigned n = 0; n < NUM_LEDS; n++) begin
            case (mode_i[MODE_W*n +: MODE_W])
                MODE_OFF: led_d[n] = 1'b0;
                MODE_ON:  led_d[n] = 1'b1;
                MODE_HB:  led_d[n] = heartbeat_c;
                MODE_PWM: led_d[n] = (pwm_cnt_q < duty_i[PWM_WIDTH*n +: PWM_WIDTH]);
                default:  led_d[n] = 1'b0;
            endcase
        end
        case (state_q)
            ST_EXIT_PASS: led_d = '1;
            ST_EXIT_FAIL: led_d = {NUM_LEDS{heartbeat_c}};
            default:      ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            exit_valid_q   <= 1'b0;
            state_q        <= ST_NORMAL;
            exit_latched_q <= 1'b0;
            led_q          <= '0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            exit_valid_q   <= exit_valid_d;
            state_q        <= state_d;
            exit_latched_q <= exit_latched_d;
            led_q          <= led_d;
        end
    end

    assign led_o          = led_q;
    assign heartbeat_o    = heartbeat_c;
    assign exit_latched_o = exit_latched_q;

endmodule

// File: tb/tb_fpga_status_leds.sv
// Self-checking bench for fpga_status_leds against a time-based reference model.
module tb_fpga_status_leds;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mode = '0;
    logic [11:0] duty = '0;
    logic        ev = 1'b0;
    logic        evv = 1'b0;
    logic [3:0]  led;
    logic        hb;
    logic        latched;

    int checks = 0;
    int failures = 0;

    fpga_status_leds #(.NUM_LEDS(4), .DIV_WIDTH(4), .PWM_WIDTH(3)) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .duty_i(duty),
        .exit_valid_i(ev), .exit_value_i(evv),
        .led_o(led), .heartbeat_o(hb), .exit_latched_o(latched)
    );

    always #5 clk = ~clk;

    // Reference model: everything derives from cycles elapsed since reset.
    // m_exit: 0 running normally, 1 passed, 2 failed.
    int         m_t = 0;
    logic       m_prev_v = 1'b0;
    int         m_exit = 0;
    logic [3:0] m_led = '0;

    function automatic logic hb_at(input int t);
        return ((t / 8) % 2) == 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t <= 0; m_prev_v <= 1'b0; m_exit <= 0; m_led <= '0;
        end else begin
            logic [3:0] nl;
            for (int n = 0; n < 4; n++) begin
                int md, dt;
                md = (mode >> (2*n)) & 3;
                dt = (duty >> (3*n)) & 7;
                if (md == 1) nl[n] = 1'b1;
                else if (md == 2) nl[n] = hb_at(m_t);
                else if (md == 3) nl[n] = ((m_t % 8) < dt);
                else nl[n] = 1'b0;
            end
            if (m_exit == 1) nl = 4'hF;
            if (m_exit == 2) nl = {4{hb_at(m_t)}};
            m_led <= nl;
            if (m_exit == 0 && ev && !m_prev_v) m_exit <= evv ? 2 : 1;
            m_prev_v <= ev;
            m_t <= m_t + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; ev = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; ev = 1'b0; mode = 8'h55;
        repeat (2) @(negedge clk);
        checks++;
        if (led !== 4'h0 || hb !== 1'b0 || latched !== 1'b0) begin
            failures++;
            $display("FAIL reset: led=%h hb=%b latched=%b, required led=0 hb=0 latched=0", led, hb, latched);
        end
        rst = 1'b0;
    endtask

    task automatic test_heartbeat();
        logic prev_hb;
        int   highs;
        do_reset();
        mode = 8'hAA;
        prev_hb = 1'b0;
        highs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (hb !== (((k % 16) >= 8) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL heartbeat k=%0d: hb=%b required %b", k, hb, (k % 16) >= 8);
            end
            checks++;
            if (led !== {4{prev_hb}} || latched !== 1'b0) begin
                failures++;
                $display("FAIL hb_led_lag k=%0d: led=%h latched=%b required led=%h latched=0", k, led, latched, {4{prev_hb}});
            end
            if (k > 8 && k <= 24) highs += hb;
            prev_hb = hb;
        end
        checks++;
        if (highs != 8) begin
            failures++;
            $display("FAIL hb_duty: high %0d of 16 cycles, required 8", highs);
        end
    endtask

    task automatic test_pwm();
        int duties[3] = '{0, 3, 7};
        do_reset();
        foreach (duties[i]) begin
            int high;
            @(negedge clk);
            mode = {6'($urandom), 2'b11};
            duty = {9'($urandom), 3'(duties[i])};
            @(negedge clk);
            high = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                high += led[0];
                checks++;
                if (led !== m_led || hb !== hb_at(m_t) || latched !== 1'b0) begin
                    failures++;
                    $display("FAIL pwm_model d=%0d: led=%h hb=%b latched=%b required %h %b 0", duties[i], led, hb, latched, m_led, hb_at(m_t));
                end
            end
            checks++;
            if (high != duties[i]) begin
                failures++;
                $display("FAIL pwm_duty: ch0 high %0d of 8, required %0d", high, duties[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (led !== m_led || hb !== hb_at(m_t) || latched !== 1'b0) begin
                failures++;
                $display("FAIL random c=%0d: led=%h hb=%b latched=%b required %h %b 0", c, led, hb, latched, m_led, hb_at(m_t));
            end
            mode = 8'($urandom);
            duty = 12'($urandom);
        end
    endtask

    task automatic test_pass();
        do_reset();
        mode = 8'b11_10_01_00; duty = 12'h0A5; evv = 1'b0;
        repeat (3) @(negedge clk);
        ev = 1'b1;
        @(negedge clk);
        ev = 1'b0;
        checks++;
        if (latched !== 1'b1) begin
            failures++;
            $display("FAIL pass_latch: latched=%b required 1", latched);
        end
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (led !== 4'hF || latched !== 1'b1 || m_exit != 1) begin
                failures++;
                $display("FAIL pass_hold c=%0d: led=%h latched=%b required F 1", c, led, latched);
            end
            mode = ~mode;
            evv = 1'($urandom);
            ev = 1'($urandom);
            @(negedge clk);
        end
        ev = 1'b0; evv = 1'b0;
    endtask

    task automatic test_fail_second_exit();
        do_reset();
        mode = 8'($urandom); duty = 12'($urandom); evv = 1'b1;
        repeat (5) @(negedge clk);
        ev = 1'b1;
        @(negedge clk);
        ev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 10) begin evv = 1'b0; ev = 1'b1; end
            if (c == 11) ev = 1'b0;
            mode = 8'($urandom);
            if (c >= 1) begin
                checks++;
                if (led !== {4{hb_at(m_t - 1)}} || latched !== 1'b1 || led !== m_led) begin
                    failures++;
                    $display("FAIL fail_blink c=%0d: led=%h latched=%b required %h 1", c, led, latched, {4{hb_at(m_t - 1)}});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); rst = 1'b1; ev = 1'b1;
        @(negedge clk);
        checks++;
        if (led !== 4'h0 || hb !== 1'b0 || latched !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: led=%h hb=%b latched=%b required 0 0 0", led, hb, latched);
        end
        rst = 1'b0; evv = 1'b1;
        @(negedge clk);
        checks++;
        if (latched !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_edge: latched=%b required 1", latched);
        end
        @(negedge clk);
        checks++;
        if (led !== {4{hb_at(m_t - 1)}} || led !== m_led) begin
            failures++;
            $display("FAIL reset_release_fail: led=%h required %h", led, {4{hb_at(m_t - 1)}});
        end
        ev = 1'b0;
    endtask

    task automatic test_simul_reset_exit();
        do_reset();
        mode = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1; ev = 1'b1; evv = 1'b0;
        @(negedge clk);
        ev = 1'b0; rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (latched !== 1'b0 || led !== 4'h0) begin
                failures++;
                $display("FAIL simul_reset c=%0d: latched=%b led=%h required 0 0", c, latched, led);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_pwm();
        test_random();
        test_pass();
        test_fail_second_exit();
        test_reset_mid();
        test_simul_reset_exit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
